// File: rtl/wallace_mult_arbiter_if.sv
// Requester/response bundle between client units and the shared 8x8 multiplier arbiter.
// master = client side, slave = arbiter side.
interface wallace_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/wallace_mult_arbiter.sv
// Round-robin sharing of one 8x8 Wallace-tree multiplier among NUM_REQ requesters.
// Define WALLACE_MULT_ARB_ZERO_SKIP_EN to answer zero-operand requests in one clock.

module wallace_multiplier_8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [15:0] w_pp [8];
  logic [15:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2;
  logic [15:0] w_s3, w_c3, w_s4, w_c4, w_s5, w_c5;

  // 3:2 compressor on whole rows; the dropped carry-out never matters since the product fits 16 bits
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_pp[i] = {8'b0, i_a & {8{i_b[i]}}} << i;
    end
  end

  assign {w_c0, w_s0} = csa(w_pp[0], w_pp[1], w_pp[2]);
  assign {w_c1, w_s1} = csa(w_pp[3], w_pp[4], w_pp[5]);
  assign {w_c2, w_s2} = csa(w_s0, w_c0, w_s1);
  assign {w_c3, w_s3} = csa(w_c1, w_pp[6], w_pp[7]);
  assign {w_c4, w_s4} = csa(w_s2, w_c2, w_s3);
  assign {w_c5, w_s5} = csa(w_s4, w_c4, w_c3);

  assign o_p = w_s5 + w_c5;
endmodule

// state | meaning
// IDLE  | no operation in flight, waiting for any req_valid
// CALC  | latched operands feeding the multiplier
// RESP  | result held on the response channel until rsp_ready
module wallace_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  wallace_mult_arbiter_if.slave bus,
  output logic                  o_busy,
  output logic [15:0]           o_op_count
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] r_rsp_id;
  logic [7:0]      r_op_a;
  logic [7:0]      r_op_b;
  logic [15:0]     r_rsp_p;
  logic            r_rsp_valid;
  logic [15:0]     r_op_count;

  logic [ID_W-1:0] w_grant_idx;
  logic            w_grant_found;
  logic [7:0]      w_sel_a;
  logic [7:0]      w_sel_b;
  logic            w_rsp_hs;
  logic            w_grant_en;
  logic            w_accept;
  logic            w_zero;
  logic [15:0]     w_prod;

  wallace_multiplier_8 u_mult (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  // Search starts one past the last winner so every requester gets a turn
  always_comb begin
    int k;
    k             = 0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(r_last) + i) % NUM_REQ;
      if (!w_grant_found && bus.req_valid[k]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = ID_W'(k);
      end
    end
  end

  always_comb begin
    w_sel_a = 8'h00;
    w_sel_b = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a = bus.req_a[8*i +: 8];
        w_sel_b = bus.req_b[8*i +: 8];
      end
    end
  end

  assign w_rsp_hs   = (r_state == S_RESP) && bus.rsp_ready;
  assign w_grant_en = !i_rst && ((r_state == S_IDLE) || w_rsp_hs);
  assign w_accept   = w_grant_en && w_grant_found;

`ifdef WALLACE_MULT_ARB_ZERO_SKIP_EN
  assign w_zero = (w_sel_a == 8'h00) || (w_sel_b == 8'h00);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero ? S_RESP : S_CALC;
        end
      end
      S_CALC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          if (w_accept) begin
            w_state_nxt = w_zero ? S_RESP : S_CALC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) begin
      bus.req_ready[w_grant_idx] = 1'b1;
    end
    o_busy = (r_state != S_IDLE);
  end

  // Handshake retires the old response first; a same-edge zero-skip accept may then re-raise rsp_valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last      <= ID_W'(NUM_REQ - 1);
      r_rsp_id    <= '0;
      r_op_a      <= 8'h00;
      r_op_b      <= 8'h00;
      r_rsp_p     <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_op_count  <= 16'h0000;
    end else begin
      if (w_rsp_hs) begin
        r_op_count  <= r_op_count + 16'd1;
        r_rsp_valid <= 1'b0;
      end
      if (w_accept) begin
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
        r_rsp_id <= w_grant_idx;
        r_last   <= w_grant_idx;
        if (w_zero) begin
          r_rsp_p     <= 16'h0000;
          r_rsp_valid <= 1'b1;
        end
      end
      if (r_state == S_CALC) begin
        r_rsp_p     <= w_prod;
        r_rsp_valid <= 1'b1;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_p     = r_rsp_p;
  assign o_op_count    = r_op_count;
endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Scoreboard bench for wallace_mult_arbiter; expected latency follows WALLACE_MULT_ARB_ZERO_SKIP_EN.
module tb_wallace_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef WALLACE_MULT_ARB_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] op_count;
  int          cyc = 0;

  wallace_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  wallace_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_busy     (busy),
    .o_op_count (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int p;
    int gcyc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per response handshake
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;
  int   start_cyc  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (bus.rsp_valid && (!prev_valid || prev_hs)) start_cyc = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got id %0d p 0x%0h with no response outstanding",
                   bus.rsp_id, bus.rsp_p);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(bus.rsp_id), e.id);
          check("rsp_p", 32'(bus.rsp_p), e.p);
          check("latency", start_cyc - e.gcyc, e.lat);
        end
      end
      prev_valid = bus.rsp_valid;
      prev_hs    = bus.rsp_valid && bus.rsp_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[i]    = v;
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  // Waits (bounded) for a grant, checks it, optionally queues the response; returns at posedge+1
  task automatic expect_grant(input int id, input int p, input int lat, input bit push,
                              output int gc);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("grant_%0d", id), 32'(bus.req_ready), 32'(1 << id));
    gc = cyc;
    if (push && bus.req_ready != '0) sb.push_back('{id, p, cyc, lat});
    tick();
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((busy || sb.size() != 0) && w < 40) begin
      tick();
      w++;
    end
    check("drain_idle", {30'b0, busy, sb.size() != 0}, 0);
  endtask

  task automatic op1(input int r, input logic [7:0] a, input logic [7:0] b, input int p,
                     input int lat);
    int gc;
    set_req(r, 1'b1, a, b);
    expect_grant(r, p, lat, 1'b1, gc);
    bus.req_valid[r] = 1'b0;
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc;
    int prev_gc;
    int order3[5];
    int order6[4];
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    int tp[4];
    int w;

    order3 = '{0, 1, 2, 3, 0};
    order6 = '{2, 3, 0, 1};
    ta = '{8'h03, 8'h10, 8'h7F, 8'hC8};
    tb = '{8'h05, 8'h10, 8'h02, 8'h0A};
    tp = '{'h000F, 'h0100, 'h00FE, 'h07D0};

    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_p", 32'(bus.rsp_p), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_count", 32'(op_count), 0);
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // single request, same-cycle ready
    op1(0, 8'h0C, 8'h0D, 'h009C, 2);
    check("op_count_t1", 32'(op_count), 1);

    // corner products on requester 2
    op1(2, 8'hFF, 8'hFF, 'hFE01, 2);
    op1(2, 8'h80, 8'h02, 'h0100, 2);
    op1(2, 8'h01, 8'hA5, 'h00A5, 2);
    check("op_count_t2", 32'(op_count), 4);

    // all four held valid from reset
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, ta[i], tb[i]);
    tick();
    rst = 1'b0;
    prev_gc = 0;
    for (int k = 0; k < 5; k++) begin
      expect_grant(order3[k], tp[order3[k]], 2, 1'b1, gc);
      if (k > 0) check("accept_spacing", gc - prev_gc, 2);
      prev_gc = gc;
    end
    bus.req_valid = '0;
    drain();
    check("op_count_t3", 32'(op_count), 5);

    // backpressure with a competing request pending
    bus.rsp_ready = 1'b0;
    set_req(1, 1'b1, 8'h12, 8'h34);
    expect_grant(1, 'h03A8, 2, 1'b1, gc);
    bus.req_valid[1] = 1'b0;
    set_req(3, 1'b1, 8'h09, 8'h09);
    w = 0;
    @(negedge clk);
    while (!bus.rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_id", 32'(bus.rsp_id), 1);
      check("bp_rsp_p", 32'(bus.rsp_p), 'h03A8);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      check("bp_op_count", 32'(op_count), 5);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    expect_grant(3, 'h0051, 2, 1'b1, gc);
    bus.req_valid[3] = 1'b0;
    drain();
    check("op_count_t4", 32'(op_count), 7);

    // reset while an operation sits in CALC
    set_req(3, 1'b1, 8'h11, 8'h22);
    expect_grant(3, 'h0242, 2, 1'b0, gc);
    bus.req_valid[3] = 1'b0;
    rst = 1'b1;
    set_req(0, 1'b1, 8'h02, 8'h03);
    set_req(1, 1'b1, 8'h04, 8'h05);
    tick();
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_op_count", 32'(op_count), 0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_grant(0, 'h0006, 2, 1'b1, gc);
    bus.req_valid[0] = 1'b0;
    expect_grant(1, 'h0014, 2, 1'b1, gc);
    bus.req_valid[1] = 1'b0;
    drain();
    check("op_count_t5", 32'(op_count), 2);

    // all requesting with last = 1
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, ta[i], tb[i]);
    for (int k = 0; k < 4; k++) begin
      expect_grant(order6[k], tp[order6[k]], 2, 1'b1, gc);
      bus.req_valid[order6[k]] = 1'b0;
    end
    drain();
    check("op_count_t6", 32'(op_count), 6);

    // zero operands
    op1(1, 8'h00, 8'h37, 'h0000, ZLAT);
    op1(2, 8'h5A, 8'h00, 'h0000, ZLAT);
    check("op_count_t7", 32'(op_count), 8);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
